// File: rtl/vx_lane_reduce_unit.sv
// Cross-lane reduction unit: folds rs1 of every active thread of a warp into one scalar commit.
// Optional feature: define VX_REDUCE_MINMAX_EN to enable MIN/MAX/MINU/MAXU (ops 4-7).

`ifndef XLEN
`define XLEN 32
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 8
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
`ifndef UP
`define UP(x) (((x) != 0) ? (x) : 1)
`endif

module vx_lane_reduce_unit #(
    parameter int CORE_ID   = 0,
    parameter int NUM_LANES = 4,
    parameter int PID_WIDTH = `UP(`CLOG2(`NUM_THREADS / NUM_LANES))
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [`UUID_WIDTH-1:0]       in_uuid,
    input  logic [`NW_WIDTH-1:0]         in_wid,
    input  logic [NUM_LANES-1:0]         in_tmask,
    input  logic [`XLEN-1:0]             in_PC,
    input  logic [`NR_BITS-1:0]          in_rd,
    input  logic                         in_wb,
    input  logic [2:0]                   in_op,
    input  logic [NUM_LANES*`XLEN-1:0]   in_rs1_data,
    input  logic [PID_WIDTH-1:0]         in_pid,
    input  logic                         in_sop,
    input  logic                         in_eop,

    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [`UUID_WIDTH-1:0]       out_uuid,
    output logic [`NW_WIDTH-1:0]         out_wid,
    output logic [NUM_LANES-1:0]         out_tmask,
    output logic [`XLEN-1:0]             out_PC,
    output logic [`NR_BITS-1:0]          out_rd,
    output logic                         out_wb,
    output logic [NUM_LANES*`XLEN-1:0]   out_data,
    output logic [PID_WIDTH-1:0]         out_pid,
    output logic                         out_sop,
    output logic                         out_eop
);

    localparam int XLEN  = `XLEN;
    localparam int CNT_W = `UP(`CLOG2(NUM_LANES));
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_LANES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_MIN  = 3'd4;
    localparam logic [2:0] OP_MAX  = 3'd5;
    localparam logic [2:0] OP_MINU = 3'd6;
    localparam logic [2:0] OP_MAXU = 3'd7;

    // Unsupported ops fall to the default arm, so their identity and fold are both zero.
    function automatic logic [XLEN-1:0] identityOf(input logic [2:0] op);
        case (op)
            OP_AND:  identityOf = '1;
`ifdef VX_REDUCE_MINMAX_EN
            OP_MINU: identityOf = '1;
            OP_MIN:  identityOf = {1'b0, {(XLEN-1){1'b1}}};
            OP_MAX:  identityOf = {1'b1, {(XLEN-1){1'b0}}};
`endif
            default: identityOf = '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] combine(input logic [2:0] op,
                                                input logic [XLEN-1:0] acc,
                                                input logic [XLEN-1:0] lane);
        case (op)
            OP_ADD:  combine = acc + lane;
            OP_AND:  combine = acc & lane;
            OP_OR:   combine = acc | lane;
            OP_XOR:  combine = acc ^ lane;
`ifdef VX_REDUCE_MINMAX_EN
            OP_MIN:  combine = ($signed(lane) < $signed(acc)) ? lane : acc;
            OP_MAX:  combine = ($signed(lane) > $signed(acc)) ? lane : acc;
            OP_MINU: combine = (lane < acc) ? lane : acc;
            OP_MAXU: combine = (lane > acc) ? lane : acc;
`endif
            default: combine = '0;
        endcase
    endfunction

    logic [1:0]                 r_state;
    logic [CNT_W-1:0]           r_counter;
    logic [NUM_LANES*XLEN-1:0]  r_lanes;
    logic [NUM_LANES-1:0]       r_pkt_tmask;
    logic                       r_eop;
    logic                       r_open;
    logic [XLEN-1:0]            r_acc;
    logic [2:0]                 r_op;
    logic [`UUID_WIDTH-1:0]     r_uuid;
    logic [`NW_WIDTH-1:0]       r_wid;
    logic [NUM_LANES-1:0]       r_tmask;
    logic [XLEN-1:0]            r_PC;
    logic [`NR_BITS-1:0]        r_rd;
    logic                       r_wb;

    logic [XLEN-1:0]            w_lane;
    logic [XLEN-1:0]            w_next_acc;
    logic                       w_unused_pid;

    assign w_lane       = r_lanes[int'(r_counter)*XLEN +: XLEN];
    assign w_next_acc   = combine(r_op, r_acc, w_lane);
    assign w_unused_pid = ^in_pid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_counter   <= '0;
            r_lanes     <= '0;
            r_pkt_tmask <= '0;
            r_eop       <= 1'b0;
            r_open      <= 1'b0;
            r_acc       <= '0;
            r_op        <= '0;
            r_uuid      <= '0;
            r_wid       <= '0;
            r_tmask     <= '0;
            r_PC        <= '0;
            r_rd        <= '0;
            r_wb        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_lanes     <= in_rs1_data;
                        r_pkt_tmask <= in_tmask;
                        r_eop       <= in_eop;
                        r_counter   <= '0;
                        r_open      <= !in_eop;
                        r_state     <= S_SCAN;
                        // A stray non-sop packet with no open warp is handled as a fresh warp.
                        if (in_sop || !r_open) begin
                            r_acc   <= identityOf(in_op);
                            r_op    <= in_op;
                            r_uuid  <= in_uuid;
                            r_wid   <= in_wid;
                            r_tmask <= in_tmask;
                            r_PC    <= in_PC;
                            r_rd    <= in_rd;
                            r_wb    <= in_wb;
                        end
                    end
                end
                S_SCAN: begin
                    if (r_pkt_tmask[r_counter]) begin
                        r_acc <= w_next_acc;
                    end
                    r_counter <= r_counter + 1'b1;
                    if (r_counter == LAST_LANE) begin
                        r_state <= r_eop ? S_OUT : S_IDLE;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign out_uuid  = r_uuid;
    assign out_wid   = r_wid;
    assign out_tmask = r_tmask;
    assign out_PC    = r_PC;
    assign out_rd    = r_rd;
    assign out_wb    = r_wb;
    assign out_data  = {NUM_LANES{r_acc}};
    assign out_pid   = '0;
    assign out_sop   = 1'b1;
    assign out_eop   = 1'b1;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && in_valid && in_ready) begin
            if (!in_sop && !r_open)
                $warning("[vx_lane_reduce_unit%0d] RUNTIME_ASSERT: non-sop packet with no open warp (wid=%0d)", CORE_ID, in_wid);
            if (in_sop && r_open)
                $warning("[vx_lane_reduce_unit%0d] RUNTIME_ASSERT: sop while warp open, restarting (wid=%0d)", CORE_ID, in_wid);
`ifndef VX_REDUCE_MINMAX_EN
            if (in_op[2])
                $warning("[vx_lane_reduce_unit%0d] RUNTIME_ASSERT: reduce op %0d not enabled (wid=%0d)", CORE_ID, in_op, in_wid);
`endif
        end
    end
`endif

endmodule

// File: tb/tb_vx_lane_reduce_unit.sv
// Directed bench for vx_lane_reduce_unit: hand-computed vectors checked with immediate assertions.
// Expectations for ops 4-7 follow VX_REDUCE_MINMAX_EN.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 8
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
`ifndef UP
`define UP(x) (((x) != 0) ? (x) : 1)
`endif

module tb_vx_lane_reduce_unit;

    localparam int NL = 4;
    localparam int XL = `XLEN;
    localparam int DW = NL * XL;
    localparam int PW = `UP(`CLOG2(`NUM_THREADS / NL));

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [`UUID_WIDTH-1:0]  in_uuid;
    logic [`NW_WIDTH-1:0]    in_wid;
    logic [NL-1:0]           in_tmask;
    logic [XL-1:0]           in_PC;
    logic [`NR_BITS-1:0]     in_rd;
    logic                    in_wb;
    logic [2:0]              in_op;
    logic [DW-1:0]           in_rs1_data;
    logic [PW-1:0]           in_pid;
    logic                    in_sop;
    logic                    in_eop;
    logic                    out_valid;
    logic                    out_ready;
    logic [`UUID_WIDTH-1:0]  out_uuid;
    logic [`NW_WIDTH-1:0]    out_wid;
    logic [NL-1:0]           out_tmask;
    logic [XL-1:0]           out_PC;
    logic [`NR_BITS-1:0]     out_rd;
    logic                    out_wb;
    logic [DW-1:0]           out_data;
    logic [PW-1:0]           out_pid;
    logic                    out_sop;
    logic                    out_eop;

    int vecCount  = 0;
    int missCount = 0;
    int cycle     = 0;

    vx_lane_reduce_unit #(
        .CORE_ID   (0),
        .NUM_LANES (NL),
        .PID_WIDTH (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_uuid     (in_uuid),
        .in_wid      (in_wid),
        .in_tmask    (in_tmask),
        .in_PC       (in_PC),
        .in_rd       (in_rd),
        .in_wb       (in_wb),
        .in_op       (in_op),
        .in_rs1_data (in_rs1_data),
        .in_pid      (in_pid),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_uuid    (out_uuid),
        .out_wid     (out_wid),
        .out_tmask   (out_tmask),
        .out_PC      (out_PC),
        .out_rd      (out_rd),
        .out_wb      (out_wb),
        .out_data    (out_data),
        .out_pid     (out_pid),
        .out_sop     (out_sop),
        .out_eop     (out_eop)
    );

    // Free-running clock and cycle counter used for latency measurements.
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Hard stop in case some wait slips past its own budget.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] bcast(input logic [XL-1:0] v);
        bcast = {NL{v}};
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic drivePacket(input logic [2:0] op, input logic [NL-1:0] tmask,
                               input logic [XL-1:0] l0, input logic [XL-1:0] l1,
                               input logic [XL-1:0] l2, input logic [XL-1:0] l3,
                               input logic [PW-1:0] pid, input logic sop, input logic eop);
        in_valid    = 1'b1;
        in_op       = op;
        in_tmask    = tmask;
        in_rs1_data = {l3, l2, l1, l0};
        in_pid      = pid;
        in_sop      = sop;
        in_eop      = eop;
    endtask

    // Presents a packet, waits (bounded) for acceptance, and reports the accept cycle.
    task automatic applyStimulus(input logic [2:0] op, input logic [NL-1:0] tmask,
                                 input logic [XL-1:0] l0, input logic [XL-1:0] l1,
                                 input logic [XL-1:0] l2, input logic [XL-1:0] l3,
                                 input logic [PW-1:0] pid, input logic sop, input logic eop,
                                 output int acceptCycle);
        int budget;
        drivePacket(op, tmask, l0, l1, l2, l3, pid, sop, eop);
        budget = 0;
        while (in_ready !== 1'b1 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        checkOutput("accept_ready", DW'(in_ready), DW'(1));
        acceptCycle = cycle;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitReady(output int seenCycle);
        int budget;
        budget = 0;
        while (in_ready !== 1'b1 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        checkOutput("ready_return", DW'(in_ready), DW'(1));
        seenCycle = cycle;
    endtask

    task automatic waitOut(output int seenCycle);
        int budget;
        budget = 0;
        while (out_valid !== 1'b1 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        checkOutput("out_valid_seen", DW'(out_valid), DW'(1));
        seenCycle = cycle;
    endtask

    // Checks the commit packet, then completes the handshake.
    task automatic collect(input string tag, input logic [XL-1:0] expData, input logic [NL-1:0] expTmask);
        checkOutput({tag, "_data"},  out_data, bcast(expData));
        checkOutput({tag, "_tmask"}, DW'(out_tmask), DW'(expTmask));
        checkOutput({tag, "_pid"},   DW'(out_pid), DW'(0));
        checkOutput({tag, "_soeop"}, DW'({out_sop, out_eop}), DW'(2'b11));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "_post_ready"}, DW'(in_ready), DW'(1));
        checkOutput({tag, "_post_valid"}, DW'(out_valid), DW'(0));
    endtask

    logic [XL-1:0] expMin, expMinu, expMax;
    int tA, tB, tO;

    initial begin
`ifdef VX_REDUCE_MINMAX_EN
        expMin  = 32'hFFFF_FFFB;
        expMinu = 32'd9;
        expMax  = 32'd7;
`else
        expMin  = 32'd0;
        expMinu = 32'd0;
        expMax  = 32'd0;
`endif
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_uuid     = '0;
        in_wid      = '0;
        in_tmask    = '0;
        in_PC       = '0;
        in_rd       = '0;
        in_wb       = 1'b0;
        in_op       = '0;
        in_rs1_data = '0;
        in_pid      = '0;
        in_sop      = 1'b0;
        in_eop      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready",  DW'(in_ready), DW'(1));
        checkOutput("reset_out_valid", DW'(out_valid), DW'(0));
        checkOutput("reset_out_data",  out_data, DW'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // ADD over two packets; header comes from the sop packet.
        in_uuid = 44'h123; in_wid = 2'd1; in_PC = 32'h1000; in_rd = 5'd7; in_wb = 1'b1;
        applyStimulus(3'd0, 4'b1111, 1, 2, 3, 4, 1'b0, 1'b1, 1'b0, tA);
        checkOutput("add_scan_busy", DW'(in_ready), DW'(0));
        waitReady(tO);
        checkOutput("add_ready_latency", DW'(tO - tA), DW'(NL + 1));
        in_PC = 32'h2000; in_rd = 5'd3;
        applyStimulus(3'd0, 4'b1111, 5, 6, 7, 8, 1'b1, 1'b0, 1'b1, tB);
        waitOut(tO);
        checkOutput("add_out_latency", DW'(tO - tB), DW'(NL + 1));
        checkOutput("add_uuid", DW'(out_uuid), DW'(44'h123));
        checkOutput("add_wid",  DW'(out_wid), DW'(1));
        checkOutput("add_PC",   DW'(out_PC), DW'(32'h1000));
        checkOutput("add_rd",   DW'(out_rd), DW'(7));
        checkOutput("add_wb",   DW'(out_wb), DW'(1));
        collect("add", 32'd36, 4'b1111);

        // MIN / MINU over lanes 1 and 3 only.
        in_wb = 1'b0;
        applyStimulus(3'd4, 4'b1010, 100, -5, 100, 9, 1'b0, 1'b1, 1'b1, tA);
        waitOut(tO);
        collect("min", expMin, 4'b1010);
        applyStimulus(3'd6, 4'b1010, 100, -5, 100, 9, 1'b0, 1'b1, 1'b1, tA);
        waitOut(tO);
        collect("minu", expMinu, 4'b1010);

        // AND with no active lane anywhere yields the identity.
        applyStimulus(3'd1, 4'b0000, 1, 2, 3, 4, 1'b0, 1'b1, 1'b0, tA);
        waitReady(tO);
        applyStimulus(3'd1, 4'b0000, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1, tA);
        waitOut(tO);
        collect("and_empty", 32'hFFFF_FFFF, 4'b0000);

        applyStimulus(3'd3, 4'b1111, 32'hF0, 32'h0F, 32'hFF, 32'h01, 1'b0, 1'b1, 1'b1, tA);
        waitOut(tO);
        collect("xor", 32'd1, 4'b1111);

        applyStimulus(3'd2, 4'b0110, 1, 2, 4, 8, 1'b0, 1'b1, 1'b1, tA);
        waitOut(tO);
        collect("or", 32'd6, 4'b0110);

        applyStimulus(3'd0, 4'b0011, 32'hFFFF_FFFF, 2, 0, 0, 1'b0, 1'b1, 1'b1, tA);
        waitOut(tO);
        collect("add_wrap", 32'd1, 4'b0011);

        // A second sop while a warp is open restarts the accumulation.
        applyStimulus(3'd0, 4'b1111, 10, 0, 0, 0, 1'b0, 1'b1, 1'b0, tA);
        waitReady(tO);
        applyStimulus(3'd0, 4'b1111, 1, 2, 3, 4, 1'b0, 1'b1, 1'b1, tA);
        waitOut(tO);
        collect("restart", 32'd10, 4'b1111);

        // Back-pressure: out_ready low for 10 cycles while a new packet waits.
        applyStimulus(3'd0, 4'b1111, 1, 2, 3, 4, 1'b0, 1'b1, 1'b1, tA);
        waitOut(tO);
        drivePacket(3'd0, 4'b1111, 5, 5, 5, 5, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("stall_valid", DW'(out_valid), DW'(1));
            checkOutput("stall_data",  out_data, bcast(32'd10));
            checkOutput("stall_ready", DW'(in_ready), DW'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("stall_release_ready", DW'(in_ready), DW'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("stall_accepted", DW'(in_ready), DW'(0));
        waitOut(tO);
        collect("stall_next", 32'd20, 4'b1111);

        // Reset in the middle of a non-eop scan, then a fresh warp.
        applyStimulus(3'd0, 4'b1111, 100, 100, 100, 100, 1'b0, 1'b1, 1'b0, tA);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checkOutput("midreset_ready", DW'(in_ready), DW'(1));
        checkOutput("midreset_valid", DW'(out_valid), DW'(0));
        checkOutput("midreset_data",  out_data, DW'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        applyStimulus(3'd0, 4'b1111, 1, 1, 1, 1, 1'b0, 1'b1, 1'b1, tA);
        waitOut(tO);
        collect("after_reset", 32'd4, 4'b1111);

        // MAX: zero when the min/max ops are compiled out.
        applyStimulus(3'd5, 4'b1111, 3, -1, 7, 2, 1'b0, 1'b1, 1'b1, tA);
        waitOut(tO);
        collect("max", expMax, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
